// File: rtl/mem_arbiter.sv
// Byte-serial arbiter for the shared memory/IO port between instruction fetch and the load/store buffer.
// Splits 1/2/4-byte requests into byte accesses, assembles reads little-endian and alternates grants between requesters.
module mem_arbiter #(
  parameter int         ADDR_WIDTH = 32,
  parameter logic [1:0] IO_SEL     = 2'b11
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clear_in,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_done,
  output logic [31:0]           if_data,
  input  logic                  slb_req,
  input  logic                  slb_wr,
  input  logic [1:0]            slb_len,
  input  logic [ADDR_WIDTH-1:0] slb_addr,
  input  logic [31:0]           slb_wdata,
  output logic                  slb_done,
  output logic [31:0]           slb_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  typedef enum logic [1:0] {IDLE = 2'd0, IF_RD = 2'd1, SLB_RD = 2'd2, SLB_WR = 2'd3} state_t;
  localparam logic GRANT_IF  = 1'b0;
  localparam logic GRANT_SLB = 1'b1;

  state_t                state_r, state_s;
  logic [2:0]            idx_r, idx_s, len_r, len_s, idx_m1_s;
  logic [ADDR_WIDTH-1:0] base_r, base_s, cur_addr_s, addr_s, mem_a_hold_r;
  logic [31:0]           wdata_r, wdata_s, data_r, data_s;
  logic [31:0]           if_data_r, if_data_s, slb_rdata_r, slb_rdata_s;
  logic                  last_grant_r, last_grant_s;
  logic                  if_done_r, if_done_s, slb_done_r, slb_done_s;
  logic                  if_elig_s, slb_elig_s, grant_if_s, grant_slb_s;
  logic                  io_stall_s, wr_s;
  logic [7:0]            dout_s;

  // Byte count for an SLB length code; code 3 is treated as a word
  function automatic logic [2:0] len_decode(input logic [1:0] code);
    logic [2:0] n;
    case (code)
      2'd0:    n = 3'd1;
      2'd1:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Eligibility, round-robin grant and memory pin values for the current state
  always_comb begin
    cur_addr_s  = base_r + {{(ADDR_WIDTH-3){1'b0}}, idx_r};
    idx_m1_s    = idx_r - 3'd1;
    io_stall_s  = (base_r[17:16] == IO_SEL) && io_buffer_full;
    // a done still pending blocks re-granting the request that produced it
    if_elig_s   = if_req && !clear_in && !if_done_r;
    slb_elig_s  = slb_req && (slb_wr || !clear_in) && !slb_done_r;
    grant_if_s  = if_elig_s && (!slb_elig_s || (last_grant_r == GRANT_SLB));
    grant_slb_s = slb_elig_s && !grant_if_s;
    addr_s      = '0;
    dout_s      = 8'h00;
    wr_s        = 1'b0;
    case (state_r)
      IF_RD, SLB_RD: begin
        if (idx_r < len_r) addr_s = cur_addr_s;
        else               addr_s = '0;
      end
      SLB_WR: begin
        addr_s = cur_addr_s;
        dout_s = wdata_r[{idx_r[1:0], 3'b000} +: 8];
        wr_s   = !io_stall_s;
      end
      default: addr_s = '0;
    endcase
  end

  // Next-state, byte sequencing and read-data assembly
  always_comb begin
    state_s      = state_r;
    idx_s        = idx_r;
    len_s        = len_r;
    base_s       = base_r;
    wdata_s      = wdata_r;
    data_s       = data_r;
    last_grant_s = last_grant_r;
    if_done_s    = if_done_r;
    slb_done_s   = slb_done_r;
    if_data_s    = if_data_r;
    slb_rdata_s  = slb_rdata_r;
    if (rdy_in) begin
      if_done_s  = 1'b0;
      slb_done_s = 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_if_s) begin
            state_s      = IF_RD;
            base_s       = if_addr;
            len_s        = 3'd4;
            idx_s        = 3'd0;
            data_s       = 32'h0000_0000;
            last_grant_s = GRANT_IF;
          end else if (grant_slb_s) begin
            state_s      = slb_wr ? SLB_WR : SLB_RD;
            base_s       = slb_addr;
            len_s        = len_decode(slb_len);
            wdata_s      = slb_wdata;
            idx_s        = 3'd0;
            data_s       = 32'h0000_0000;
            last_grant_s = GRANT_SLB;
          end else begin
            state_s = IDLE;
          end
        end
        IF_RD, SLB_RD: begin
          if (clear_in) begin
            state_s = IDLE;
            idx_s   = 3'd0;
          end else begin
            // mem_din carries the byte addressed one cycle earlier
            if (idx_r != 3'd0) data_s[{idx_m1_s[1:0], 3'b000} +: 8] = mem_din;
            else               data_s = data_r;
            if (idx_r == len_r) begin
              state_s = IDLE;
              idx_s   = 3'd0;
              if (state_r == IF_RD) begin
                if_done_s = 1'b1;
                if_data_s = data_s;
              end else begin
                slb_done_s  = 1'b1;
                slb_rdata_s = data_s;
              end
            end else begin
              idx_s = idx_r + 3'd1;
            end
          end
        end
        SLB_WR: begin
          if (io_stall_s) begin
            idx_s = idx_r;
          end else if (idx_r == (len_r - 3'd1)) begin
            state_s    = IDLE;
            idx_s      = 3'd0;
            slb_done_s = 1'b1;
          end else begin
            idx_s = idx_r + 3'd1;
          end
        end
        default: state_s = IDLE;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Frozen cycles replay the previous address so the byte owed to the next capture is fetched again
  assign mem_a    = rdy_in ? addr_s : mem_a_hold_r;
  assign mem_wr   = rdy_in & wr_s;
  assign mem_dout = dout_s;
  assign if_done   = if_done_r;
  assign if_data   = if_data_r;
  assign slb_done  = slb_done_r;
  assign slb_rdata = slb_rdata_r;

  // State and datapath registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_r      <= IDLE;
      idx_r        <= 3'd0;
      len_r        <= 3'd0;
      base_r       <= '0;
      wdata_r      <= 32'h0000_0000;
      data_r       <= 32'h0000_0000;
      last_grant_r <= GRANT_IF;
      if_done_r    <= 1'b0;
      slb_done_r   <= 1'b0;
      if_data_r    <= 32'h0000_0000;
      slb_rdata_r  <= 32'h0000_0000;
      mem_a_hold_r <= '0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      len_r        <= len_s;
      base_r       <= base_s;
      wdata_r      <= wdata_s;
      data_r       <= data_s;
      last_grant_r <= last_grant_s;
      if_done_r    <= if_done_s;
      slb_done_r   <= slb_done_s;
      if_data_r    <= if_data_s;
      slb_rdata_r  <= slb_rdata_s;
      mem_a_hold_r <= mem_a;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a byte RAM, a reference byte map with expectation queues
// checked every cycle, and literal checks on latency, ordering, stalls, aborts and reset.
module tb_mem_arbiter;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clear_in;
  logic        if_req, if_done, slb_req, slb_wr, slb_done, mem_wr, io_buffer_full;
  logic [31:0] if_addr, if_data, slb_addr, slb_wdata, slb_rdata, mem_a;
  logic [1:0]  slb_len;
  logic [7:0]  mem_din, mem_dout;

  int tests = 0;
  int fails = 0;

  logic [7:0]  ram     [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] if_exp_q[$];
  logic [32:0] slb_exp_q[$];   // {is_load, data}
  logic [39:0] wr_exp_q[$];    // {addr, byte}
  logic [31:0] last_if, last_slb;
  logic        prev_if_done, prev_slb_done;

  mem_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .slb_req(slb_req), .slb_wr(slb_wr), .slb_len(slb_len), .slb_addr(slb_addr),
    .slb_wdata(slb_wdata), .slb_done(slb_done), .slb_rdata(slb_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  // RAM with one-cycle read latency
  always @(posedge clk_in) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a, input int n);
    logic [31:0] w = 32'h0;
    for (int i = 0; i < n; i++)
      if (ref_mem.exists(a + 32'(i))) w = w | (32'(ref_mem[a + 32'(i)]) << (8 * i));
    return w;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a] = b;
    ref_mem[a] = b;
  endtask

  task automatic idle_cycle();
    @(posedge clk_in); #2;
  endtask

  // Scoreboard: done pulses, data values, held outputs and every written byte
  always @(negedge clk_in) begin
    if (rst_in) begin
      last_if  = 32'h0;
      last_slb = 32'h0;
    end else begin
      if (if_done) begin
        if (prev_if_done) chk("if_done width", 32'd2, 32'd1);
        if (if_exp_q.size() == 0) chk("if_done unexpected", 32'd1, 32'd0);
        else begin
          last_if = if_exp_q.pop_front();
          chk("if_data", if_data, last_if);
        end
      end else chk("if_data hold", if_data, last_if);
      if (slb_done) begin
        logic [32:0] e;
        if (prev_slb_done) chk("slb_done width", 32'd2, 32'd1);
        if (slb_exp_q.size() == 0) chk("slb_done unexpected", 32'd1, 32'd0);
        else begin
          e = slb_exp_q.pop_front();
          if (e[32]) last_slb = e[31:0];
          chk("slb_rdata", slb_rdata, last_slb);
        end
      end else chk("slb_rdata hold", slb_rdata, last_slb);
      if (mem_wr) begin
        logic [39:0] w;
        chk("write while frozen", {31'h0, rdy_in}, 32'd1);
        if (wr_exp_q.size() == 0) chk("write unexpected", 32'd1, 32'd0);
        else begin
          w = wr_exp_q.pop_front();
          chk("write addr", mem_a, w[39:8]);
          chk("write byte", {24'h0, mem_dout}, {24'h0, w[7:0]});
        end
      end
    end
    prev_if_done  = if_done;
    prev_slb_done = slb_done;
  end

  task automatic slb_op(input logic wr, input logic [1:0] len, input logic [31:0] addr,
                        input logic [31:0] wdata, input int clear_at, output int lat);
    int n;
    n = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
    if (wr) begin
      for (int i = 0; i < n; i++) begin
        wr_exp_q.push_back({addr + 32'(i), wdata[8*i +: 8]});
        ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
      end
      slb_exp_q.push_back({1'b0, 32'h0});
    end else slb_exp_q.push_back({1'b1, ref_word(addr, n)});
    slb_wr = wr; slb_len = len; slb_addr = addr; slb_wdata = wdata; slb_req = 1'b1;
    lat = 0;
    do begin
      @(posedge clk_in); #1;
      lat++;
      clear_in = (lat == clear_at);
      #1;
    end while (!slb_done && lat < 60);
    if (!slb_done) chk("slb timeout", 32'd0, 32'd1);
    slb_req = 1'b0; clear_in = 1'b0;
    idle_cycle();
  endtask

  task automatic fetch_op(input logic [31:0] addr, output int lat);
    if_exp_q.push_back(ref_word(addr, 4));
    if_addr = addr; if_req = 1'b1;
    lat = 0;
    do begin
      @(posedge clk_in); #2;
      lat++;
    end while (!if_done && lat < 60);
    if (!if_done) chk("fetch timeout", 32'd0, 32'd1);
    if_req = 1'b0;
    idle_cycle();
  endtask

  initial begin
    int lat, wr_lo, seen, nslb, code, nord;
    rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0; if_req = 1'b0; if_addr = 32'h0;
    slb_req = 1'b0; slb_wr = 1'b0; slb_len = 2'd0; slb_addr = 32'h0; slb_wdata = 32'h0;
    io_buffer_full = 1'b0;
    preload(32'h100, 8'h13); preload(32'h101, 8'h05); preload(32'h102, 8'h10); preload(32'h103, 8'h00);
    preload(32'h10, 8'h34);  preload(32'h11, 8'h12);
    #3;
    chk("reset mem_a", mem_a, 32'h0);
    chk("reset mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("reset mem_dout", {24'h0, mem_dout}, 32'h0);
    chk("reset dones", {30'h0, if_done, slb_done}, 32'h0);
    chk("reset data", if_data | slb_rdata, 32'h0);
    #9 rst_in = 1'b0;
    idle_cycle();

    // Word fetch: byte addresses in order, done six cycles after the grant edge, no re-grant
    if_exp_q.push_back(ref_word(32'h100, 4));
    if_addr = 32'h100; if_req = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk_in); #2;
      if (k < 4) begin
        chk("fetch mem_a", mem_a, 32'h100 + 32'(k));
        chk("fetch mem_wr", {31'h0, mem_wr}, 32'h0);
      end
      if (k == 4) chk("fetch early done", {31'h0, if_done}, 32'h0);
      if (k == 5) begin
        chk("fetch done", {31'h0, if_done}, 32'h1);
        chk("fetch word", if_data, 32'h00100513);
      end
      if (k == 6) begin
        chk("fetch no regrant", mem_a, 32'h0);
        chk("fetch single pulse", {31'h0, if_done}, 32'h0);
        if_req = 1'b0;
      end
    end
    idle_cycle();

    // Word store then load-back
    slb_op(1'b1, 2'd2, 32'h200, 32'hDEADBEEF, -1, lat);
    chk("store latency", 32'(lat), 32'd5);
    slb_op(1'b0, 2'd2, 32'h200, 32'h0, -1, lat);
    chk("load latency", 32'(lat), 32'd6);
    chk("load back", slb_rdata, 32'hDEADBEEF);

    // Alternation: last grant IF, so SLB first, then IF, then the repeated SLB
    fetch_op(32'h104, lat);
    slb_exp_q.push_back({1'b1, ref_word(32'h200, 1)});
    if_exp_q.push_back(ref_word(32'h100, 4));
    slb_exp_q.push_back({1'b1, ref_word(32'h201, 1)});
    if_addr = 32'h100; if_req = 1'b1;
    slb_wr = 1'b0; slb_len = 2'd0; slb_addr = 32'h200; slb_req = 1'b1;
    nslb = 0; code = 0; nord = 0;
    for (int c = 0; c < 80 && nord < 3; c++) begin
      @(posedge clk_in); #1;
      if (slb_done) begin
        code = code * 16 + 1; nord++; nslb++;
        if (nslb == 1) slb_addr = 32'h201;
        else slb_req = 1'b0;
      end
      if (if_done) begin
        code = code * 16 + 2; nord++;
        if_req = 1'b0;
      end
    end
    chk("arb order", 32'(code), 32'h121);
    chk("arb second load", slb_rdata, 32'h000000BE);
    if_req = 1'b0; slb_req = 1'b0;
    idle_cycle();

    // IO write held off by a full UART buffer for three cycles
    wr_exp_q.push_back({32'h30000, 8'h41});
    ref_mem[32'h30000] = 8'h41;
    slb_exp_q.push_back({1'b0, 32'h0});
    io_buffer_full = 1'b1;
    slb_wr = 1'b1; slb_len = 2'd0; slb_addr = 32'h30000; slb_wdata = 32'h41; slb_req = 1'b1;
    wr_lo = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_in); #1;
      io_buffer_full = (k < 3);
      #1;
      if (k < 3 && !mem_wr) wr_lo++;
      if (k == 3) begin
        chk("io write strobe", {31'h0, mem_wr}, 32'h1);
        chk("io write addr", mem_a, 32'h30000);
        chk("io write byte", {24'h0, mem_dout}, 32'h41);
      end
      if (k == 4) begin
        chk("io done", {31'h0, slb_done}, 32'h1);
        chk("io single write", {31'h0, mem_wr}, 32'h0);
        slb_req = 1'b0;
      end
    end
    chk("io stall cycles", 32'(wr_lo), 32'd3);
    idle_cycle();

    // Hazard during the second fetch byte aborts the read without a done
    if_addr = 32'h100; if_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_in); #1;
      if (k == 1) clear_in = 1'b1;
      if (k == 2) begin clear_in = 1'b0; if_req = 1'b0; end
      #1;
      if (k == 2) begin
        chk("abort mem_a", mem_a, 32'h0);
        chk("abort mem_wr", {31'h0, mem_wr}, 32'h0);
      end
    end
    seen = 0;
    repeat (10) begin
      @(posedge clk_in); #2;
      if (if_done) seen++;
    end
    chk("abort no done", 32'(seen), 32'd0);

    // Hazard during a store is ignored
    slb_op(1'b1, 2'd2, 32'h210, 32'h11223344, 2, lat);
    chk("store under clear latency", 32'(lat), 32'd5);
    slb_op(1'b0, 2'd3, 32'h210, 32'h0, -1, lat);
    chk("store under clear data", slb_rdata, 32'h11223344);

    // Halfword load, then the same load frozen for two cycles
    slb_op(1'b0, 2'd1, 32'h10, 32'h0, -1, lat);
    chk("half latency", 32'(lat), 32'd4);
    chk("half data", slb_rdata, 32'h00001234);
    slb_exp_q.push_back({1'b1, ref_word(32'h10, 2)});
    slb_wr = 1'b0; slb_len = 2'd1; slb_addr = 32'h10; slb_req = 1'b1;
    lat = 0;
    do begin
      @(posedge clk_in); #1;
      lat++;
      rdy_in = !(lat == 2 || lat == 3);
      #1;
      if (lat == 2 || lat == 3) begin
        chk("frozen mem_a", mem_a, 32'h10);
        chk("frozen mem_wr", {31'h0, mem_wr}, 32'h0);
      end
    end while (!slb_done && lat < 40);
    rdy_in = 1'b1;
    chk("frozen latency", 32'(lat), 32'd6);
    chk("frozen data", slb_rdata, 32'h00001234);
    slb_req = 1'b0;
    idle_cycle();

    // Asynchronous reset in the middle of a fetch
    if_addr = 32'h100; if_req = 1'b1;
    repeat (3) @(posedge clk_in);
    #3 rst_in = 1'b1;
    #1;
    chk("async mem_a", mem_a, 32'h0);
    chk("async mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("async if_data", if_data, 32'h0);
    chk("async slb_rdata", slb_rdata, 32'h0);
    chk("async dones", {30'h0, if_done, slb_done}, 32'h0);
    if_req = 1'b0;
    @(posedge clk_in); #1 rst_in = 1'b0;
    repeat (3) idle_cycle();

    chk("if queue drained", 32'(if_exp_q.size()), 32'd0);
    chk("slb queue drained", 32'(slb_exp_q.size()), 32'd0);
    chk("write queue drained", 32'(wr_exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single byte-wide memory/IO port between instruction fetch (IF) and the load/store buffer (SLB).
- Breaks 1/2/4-byte requests into byte accesses, assembles read data little-endian, and handles the one-cycle read latency.
- Stalls IO writes while the UART buffer is full, aborts speculative reads on a control hazard, and guarantees fairness between requesters.
- Sits between IF/SLB and the cpu memory pins, replacing the combinational port-sharing logic.

Parameters:
- ADDR_WIDTH, 32, width of all address buses
- IO_SEL, 2'b11, value of addr[17:16] that marks an IO access

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset, asynchronous, active-high
- rdy_in  input  1  global enable; low freezes the block
- clear_in  input  1  control hazard; aborts in-flight and new reads
- if_req  input  1  IF requests a 4-byte fetch
- if_addr  input  32  fetch address
- if_done  output  1  one-cycle pulse; if_data valid
- if_data  output  32  fetched instruction word
- slb_req  input  1  SLB access request
- slb_wr  input  1  1 = store, 0 = load
- slb_len  input  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes (3 is treated as 4)
- slb_addr  input  32  access address
- slb_wdata  input  32  store data, byte 0 written first
- slb_done  output  1  one-cycle pulse; load data valid or store complete
- slb_rdata  output  32  load data, zero-extended
- mem_din  input  8  RAM/IO read byte, valid one cycle after its address
- mem_dout  output  8  write byte
- mem_a  output  32  byte address
- mem_wr  output  1  1 = write
- io_buffer_full  input  1  UART buffer full

Behaviour:
- Reset (async) state:
  - State is IDLE; counters, base address, data and length registers are 0.
  - last_grant = IF.
  - if_done = slb_done = 0; if_data = slb_rdata = 0; mem_a = 0; mem_dout = 0; mem_wr = 0.
- States:
  - IDLE, IF_RD, SLB_RD, SLB_WR.
  - A 3-bit byte counter idx and a latched base address, length (N = 1/2/4) and write data.
- IDLE arbitration, evaluated on every cycle where rdy_in = 1:
  - A requester is eligible if its req is high. When clear_in = 1, IF and SLB loads are not eligible.
  - If exactly one requester is eligible, it is granted.
  - If both are eligible, the requester that is not last_grant wins. last_grant updates on each grant.
  - Grant latches the request fields and moves to the matching state with idx = 0. The first mem_a is driven in the next cycle.
  - While in IDLE: mem_a = 0, mem_wr = 0.
- Read states (IF_RD: N = 4; SLB_RD: N from slb_len):
  - For idx < N: drive mem_a = base + idx and mem_wr = 0.
  - When idx >= 1: capture mem_din into byte idx-1 of the data register.
  - idx increments each cycle.
  - On the cycle capturing byte N-1 (idx == N):
    - Register done = 1 and the full data word for the next cycle.
    - Return to IDLE.
  - A read therefore spans N+1 cycles in state, with done visible in the following cycle.
- SLB_WR:
  - Drive mem_a = base + idx, mem_dout = wdata byte idx, mem_wr = 1.
  - If base[17:16] == IO_SEL and io_buffer_full = 1:
    - Drive mem_wr = 0 and hold idx (stall).
  - Otherwise idx increments.
  - After byte N-1 is written, register slb_done = 1 for the next cycle and return to IDLE.
- Done pulses:
  - Exactly one cycle each.
  - if_data and slb_rdata hold their value until the next completion of the same requester.
  - Requesters must hold req and the request fields until they see done.
  - The first cycle after done does not re-grant the same request: done pulses on the cycle the block is already back in IDLE, and the requester drops req on seeing done.
- clear_in = 1 while in IF_RD or SLB_RD:
  - Go to IDLE the same cycle; no done is issued.
  - The next cycle drives mem_a = 0 and mem_wr = 0.
- clear_in while in SLB_WR: ignored. Committed stores always complete.
- rdy_in = 0:
  - State, idx, data and done registers are held.
  - mem_wr is forced to 0 and mem_a holds its value.
  - No capture occurs.
  - The byte at the held address is re-read after resume (capture resumes on the cycle rdy_in returns).
- Address arithmetic is ADDR_WIDTH-bit modulo. Wrap past 0xFFFFFFFF is not checked.

Test Plan:
- Fetch, memory holds 0x13,0x05,0x10,0x00 at 0x100: if_req, if_addr = 0x100.
  -> mem_a = 0x100..0x103 on consecutive cycles, mem_wr = 0.
  -> if_done pulses 6 cycles after the grant edge with if_data = 0x00100513.
- Store word: slb_wr = 1, slb_len = 2, slb_addr = 0x200, slb_wdata = 0xDEADBEEF.
  -> writes EF,BE,AD,DE to 0x200..0x203 with mem_wr = 1, then slb_done.
  -> A read back via an SLB load returns 0xDEADBEEF.
- Simultaneous requests with last_grant = IF: if_req and slb_req (1-byte load) asserted together.
  -> SLB is served first, then IF. A repeated SLB request is then served only after the IF completes (alternation).
- IO write 0x41 to 0x30000 with io_buffer_full held high for 3 cycles.
  -> mem_wr = 0 for 3 cycles, then exactly one cycle with mem_wr = 1, mem_a = 0x30000, mem_dout = 0x41, then slb_done.
- clear_in pulsed during the 2nd byte of an IF fetch.
  -> Returns to IDLE, no if_done, mem_wr = 0.
  -> clear_in pulsed during a 4-byte store: all 4 bytes are still written and slb_done is asserted.
- rdy_in low for 2 cycles during a halfword load at 0x10 (bytes 0x34,0x12).
  -> mem_a holds and mem_wr stays 0.
  -> slb_rdata = 0x00001234 with done delayed by exactly 2 cycles.
  -> Async rst_in mid-read clears all outputs immediately without waiting for a clock edge.
